// File: rtl/aura_pkg.sv
// aura_pkg: shared definitions for the attention-pipeline accumulation blocks.
//
// Contents:
//   - Default vector geometry (VA_VEC_LEN, VA_DATA_WIDTH, VA_ACC_WIDTH, VA_CNT_WIDTH)
//   - va_state_e   : vec_accum control state (ACCUM collects beats, OUTPUT presents the sum)
//   - acc_elem_t   : one signed accumulator element at the default width

package aura_pkg;

    localparam int VA_VEC_LEN    = 8;
    localparam int VA_DATA_WIDTH = 16;
    localparam int VA_ACC_WIDTH  = 24;
    localparam int VA_CNT_WIDTH  = 8;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } va_state_e;

    typedef logic signed [VA_ACC_WIDTH-1:0] acc_elem_t;

endpackage

// File: rtl/vec_accum_acc_lane.sv
// acc_lane: one signed accumulator element of vec_accum.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active-low
//   en     in   accept din this cycle
//   first  in   din starts a new group (load instead of add)
//   clr    in   zero the accumulator (group handed downstream)
//   din    in   signed input element, DATA_WIDTH bits
//   acc_q  out  signed accumulator, ACC_WIDTH bits
//
// Build option: VEC_ACCUM_SAT_EN makes each add saturate at the signed
// limits of ACC_WIDTH instead of wrapping.

module acc_lane
    import aura_pkg::*;
#(
    parameter int DATA_WIDTH = VA_DATA_WIDTH,
    parameter int ACC_WIDTH  = VA_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  first,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [ACC_WIDTH-1:0]  acc_q
);

    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] sum;

    always_comb begin
        ext = ACC_WIDTH'(signed'(din));
        sum = acc_q + ext;
`ifdef VEC_ACCUM_SAT_EN
        // Overflow only when both operands share a sign and the result flips it;
        // clamp towards the operands' sign.
        if ((acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
            (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1])) begin
            sum = acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
`endif
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = first ? ext : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/vec_accum.sv
// vec_accum: sums a group of num_vec signed vectors element-wise and emits
// one accumulated vector per group.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active-low
//   vld_in   in   upstream vector valid
//   rdy_out  out  block can accept an upstream vector (registered, state only)
//   num_vec  in   vectors per group, sampled on a group's first beat (0 means 1)
//   a        in   VEC_LEN signed elements of DATA_WIDTH bits
//   vld_out  out  accumulated vector valid (registered)
//   rdy_in   in   downstream ready
//   acc_out  out  VEC_LEN signed elements of ACC_WIDTH bits, straight from the registers
//
// Build option: VEC_ACCUM_SAT_EN selects saturating element adds (see acc_lane).

module vec_accum
    import aura_pkg::*;
#(
    parameter int VEC_LEN    = VA_VEC_LEN,
    parameter int DATA_WIDTH = VA_DATA_WIDTH,
    parameter int ACC_WIDTH  = VA_ACC_WIDTH,
    parameter int CNT_WIDTH  = VA_CNT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                vld_in,
    output logic                                rdy_out,
    input  logic [CNT_WIDTH-1:0]                num_vec,
    input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0]  a,
    output logic                                vld_out,
    input  logic                                rdy_in,
    output logic [VEC_LEN-1:0][ACC_WIDTH-1:0]   acc_out
);

    va_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic                 rdy_out_q, rdy_out_d;
    logic                 vld_out_q, vld_out_d;

    logic                 beat;
    logic                 first_beat;
    logic                 last_beat;
    logic                 out_done;
    logic [CNT_WIDTH-1:0] eff_len;

    // The count never exceeds len-1, so a group of 2^CNT_WIDTH-1 beats fits
    // without wrapping. On the first beat the freshly sampled length decides
    // whether the group is already complete.
    always_comb begin
        eff_len    = (num_vec == '0) ? CNT_WIDTH'(1) : num_vec;
        beat       = vld_in && rdy_out_q;
        first_beat = (cnt_q == '0);
        last_beat  = first_beat ? (eff_len == CNT_WIDTH'(1))
                                : (cnt_q == len_q - CNT_WIDTH'(1));
        out_done   = vld_out_q && rdy_in;

        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        case (state_q)
            ACCUM: begin
                if (beat) begin
                    if (first_beat) begin
                        len_d = eff_len;
                    end
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = OUTPUT;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            OUTPUT: begin
                if (out_done) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        rdy_out_d = (state_d == ACCUM);
        vld_out_d = (state_d == OUTPUT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            len_q     <= '0;
            rdy_out_q <= 1'b1;
            vld_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            rdy_out_q <= rdy_out_d;
            vld_out_q <= vld_out_d;
        end
    end

    assign rdy_out = rdy_out_q;
    assign vld_out = vld_out_q;

    // Lanes clear when the sum is handed downstream so the next group starts clean.
    for (genvar i = 0; i < VEC_LEN; i++) begin : g_lane
        acc_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (beat),
            .first(first_beat),
            .clr  (out_done),
            .din  (a[i]),
            .acc_q(acc_out[i])
        );
    end

endmodule

// File: tb/tb_vec_accum.sv
// tb_vec_accum: self-checking bench for vec_accum.
// Two instances share all inputs: the default geometry (ACC_WIDTH=24) and a
// narrow one (ACC_WIDTH=17) that makes wrap/saturation reachable.
// Expected sums come from a behavioural model and go through a scoreboard.

module tb_vec_accum;

    typedef logic [7:0][15:0] vin_t;
    typedef logic [7:0][23:0] v24_t;
    typedef logic [7:0][16:0] v17_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_in;
    logic [7:0]  num_vec;
    vin_t        a;
    logic        rdy_in;

    logic        rdy_out, vld_out;
    v24_t        acc_out;
    logic        rdy_out17, vld_out17;
    v17_t        acc_out17;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    longint m24[8];
    longint m17[8];
    v24_t   sb24[$];
    v17_t   sb17[$];

    vec_accum #(.VEC_LEN(8), .DATA_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out), .num_vec(num_vec),
        .a(a), .vld_out(vld_out), .rdy_in(rdy_in), .acc_out(acc_out)
    );

    vec_accum #(.VEC_LEN(8), .DATA_WIDTH(16), .ACC_WIDTH(17), .CNT_WIDTH(8)) dut17 (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out17), .num_vec(num_vec),
        .a(a), .vld_out(vld_out17), .rdy_in(rdy_in), .acc_out(acc_out17)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference add: wrap modulo 2^w, or clamp to the signed limits when saturating.
    function automatic longint mdl_add(longint acc, longint x, int w);
        longint r;
        longint lim;
        r   = acc + x;
        lim = longint'(1) << (w - 1);
`ifdef VEC_ACCUM_SAT_EN
        if (r > lim - 1) r = lim - 1;
        else if (r < -lim) r = -lim;
`else
        r = r & ((lim << 1) - 1);
        if (r >= lim) r = r - (lim << 1);
`endif
        return r;
    endfunction

    task automatic model_beat(input vin_t v, input bit first);
        longint x;
        for (int i = 0; i < 8; i++) begin
            x = longint'(signed'(v[i]));
            if (first) begin
                m24[i] = x;
                m17[i] = x;
            end else begin
                m24[i] = mdl_add(m24[i], x, 24);
                m17[i] = mdl_add(m17[i], x, 17);
            end
        end
    endtask

    task automatic model_push();
        v24_t e24;
        v17_t e17;
        longint t24, t17;
        for (int i = 0; i < 8; i++) begin
            t24 = m24[i];
            t17 = m17[i];
            e24[i] = t24[23:0];
            e17[i] = t17[16:0];
        end
        sb24.push_back(e24);
        sb17.push_back(e17);
    endtask

    // Scoreboard: a downstream transfer happens on the next rising edge whenever
    // vld_out && rdy_in are seen here, since inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst && vld_out && rdy_in) begin
            total++;
            if (sb24.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_unexpected_output acc_out=%h expected=no output", acc_out);
            end else begin
                v24_t e24;
                v17_t e17;
                e24 = sb24.pop_front();
                e17 = sb17.pop_front();
                if (acc_out !== e24) begin
                    bad++;
                    $display("[TB] FAIL sb_acc24 got=%h exp=%h", acc_out, e24);
                end
                total++;
                if (acc_out17 !== e17) begin
                    bad++;
                    $display("[TB] FAIL sb_acc17 got=%h exp=%h", acc_out17, e17);
                end
            end
        end
    end

    // Drives one upstream beat and waits (bounded) for it to be taken.
    task automatic send_beat(input vin_t v, input logic [7:0] nv, input bit first, input bit last);
        bit taken;
        int n;
        taken   = 1'b0;
        n       = 0;
        vld_in  = 1'b1;
        a       = v;
        num_vec = nv;
        while (!taken && n < 100) begin
            taken = rdy_out;
            @(posedge clk);
            #1;
            n++;
        end
        vld_in = 1'b0;
        if (!taken) begin
            total++;
            bad++;
            $display("[TB] FAIL beat_timeout rdy_out=%b expected=1", rdy_out);
        end else begin
            model_beat(v, first);
            if (last) model_push();
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb24.size() != 0 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (sb24.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s_drain pending=%0d expected=0", tag, sb24.size());
        end
    endtask

    task automatic fill(output vin_t v, input logic [15:0] val);
        for (int i = 0; i < 8; i++) v[i] = val;
    endtask

    task automatic test_reset();
        rst = 1'b0; vld_in = 1'b0; rdy_in = 1'b1; num_vec = '0; a = '0;
        repeat (2) @(posedge clk);
        #1;
        total += 4;
        if (vld_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld_out got=%b exp=0", vld_out); end
        if (rdy_out !== 1'b1) begin bad++; $display("[TB] FAIL reset_rdy_out got=%b exp=1", rdy_out); end
        if (acc_out !== '0) begin bad++; $display("[TB] FAIL reset_acc24 got=%h exp=0", acc_out); end
        if (acc_out17 !== '0) begin bad++; $display("[TB] FAIL reset_acc17 got=%h exp=0", acc_out17); end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        vin_t v;
        for (int k = 1; k <= 3; k++) begin
            fill(v, 16'(k));
            send_beat(v, 8'd3, k == 1, k == 3);
        end
        total++;
        if (vld_out !== 1'b1) begin bad++; $display("[TB] FAIL basic_latency vld_out=%b exp=1", vld_out); end
        wait_drain("basic");
    endtask

    task automatic test_signed();
        vin_t v;
        fill(v, 16'hFFFB);
        send_beat(v, 8'd2, 1'b1, 1'b0);
        fill(v, 16'h0003);
        send_beat(v, 8'd2, 1'b0, 1'b1);
        total++;
        if (acc_out[0] !== 24'hFFFFFE) begin bad++; $display("[TB] FAIL signed_elem0 got=%h exp=fffffe", acc_out[0]); end
        wait_drain("signed");
    endtask

    task automatic test_len01();
        vin_t v;
        for (int i = 0; i < 8; i++) v[i] = 16'(i);
        for (int nv = 0; nv <= 1; nv++) begin
            send_beat(v, 8'(nv), 1'b1, 1'b1);
            total++;
            if (vld_out !== 1'b1) begin bad++; $display("[TB] FAIL len%0d_latency vld_out=%b exp=1", nv, vld_out); end
            wait_drain("len01");
        end
    endtask

    task automatic test_backpressure();
        vin_t v;
        vin_t vb;
        rdy_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
            send_beat(v, 8'd2, k == 0, k == 1);
        end
        fill(vb, 16'h0123);
        vld_in = 1'b1; a = vb; num_vec = 8'd1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total += 3;
            if (vld_out !== 1'b1) begin bad++; $display("[TB] FAIL bp_vld_out got=%b exp=1", vld_out); end
            if (rdy_out !== 1'b0) begin bad++; $display("[TB] FAIL bp_rdy_out got=%b exp=0", rdy_out); end
            if (acc_out !== sb24[0]) begin bad++; $display("[TB] FAIL bp_hold got=%h exp=%h", acc_out, sb24[0]); end
        end
        model_beat(vb, 1'b1);
        model_push();
        rdy_in = 1'b1;
        @(posedge clk);
        #1;
        total += 2;
        if (vld_out !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_vld got=%b exp=0", vld_out); end
        if (rdy_out !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_rdy got=%b exp=1", rdy_out); end
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        total++;
        if (vld_out !== 1'b1) begin bad++; $display("[TB] FAIL bp_next_group vld_out=%b exp=1", vld_out); end
        wait_drain("bp");
    endtask

    task automatic test_mid_reset();
        vin_t v;
        fill(v, 16'h0055);
        send_beat(v, 8'd4, 1'b1, 1'b0);
        send_beat(v, 8'd4, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        total += 2;
        if (rdy_out !== 1'b1) begin bad++; $display("[TB] FAIL midrst_rdy got=%b exp=1", rdy_out); end
        if (acc_out !== '0) begin bad++; $display("[TB] FAIL midrst_acc got=%h exp=0", acc_out); end
        fill(v, 16'h0007);
        send_beat(v, 8'd1, 1'b1, 1'b1);
        wait_drain("midrst");
    endtask

    task automatic test_overflow();
        vin_t v;
        fill(v, 16'h7FFF);
        for (int k = 0; k < 4; k++) send_beat(v, 8'd4, k == 0, k == 3);
        total++;
`ifdef VEC_ACCUM_SAT_EN
        if (acc_out17[3] !== 17'h0FFFF) begin bad++; $display("[TB] FAIL ovf_pos17 got=%h exp=0ffff", acc_out17[3]); end
`else
        if (acc_out17[3] !== 17'h1FFFC) begin bad++; $display("[TB] FAIL ovf_pos17 got=%h exp=1fffc", acc_out17[3]); end
`endif
        wait_drain("ovf_pos");
        fill(v, 16'h8000);
        for (int k = 0; k < 4; k++) send_beat(v, 8'd4, k == 0, k == 3);
        wait_drain("ovf_neg");
    endtask

    task automatic test_max_len();
        vin_t v;
        for (int k = 0; k < 255; k++) begin
            for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
            send_beat(v, 8'd255, k == 0, k == 254);
        end
        total++;
        if (vld_out !== 1'b1) begin bad++; $display("[TB] FAIL maxlen_vld got=%b exp=1", vld_out); end
        wait_drain("maxlen");
    endtask

    task automatic test_back_to_back();
        vin_t v;
        int c0;
        int c1;
        c0 = cyc;
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 8; i++) v[i] = 16'($urandom_range(0, 2000)) - 16'd1000;
                send_beat(v, 8'd3, k == 0, k == 2);
            end
        end
        c1 = cyc;
        total++;
        if (c1 - c0 !== 11) begin bad++; $display("[TB] FAIL b2b_cycles got=%0d exp=11", c1 - c0); end
        wait_drain("b2b");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_len01();
        test_backpressure();
        test_mid_reset();
        test_overflow();
        test_max_len();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sb24.size() != 0) begin bad++; $display("[TB] FAIL final_pending got=%0d exp=0", sb24.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
